alu_rs: RTL and testbench

ALU reservation station and issue scheduler. Buffers decoded ALU and branch micro-ops from the issue stage until both source operands are available. It captures operands from two result broadcast buses (ALU and load/store buffer) and dispatches at most one ready micro-op per cycle into the single-cycle ALU. It sits between the decoder/issue logic and the ALU, and it is flushed by the ROB on misprediction.

---
 rtl/alu_rs.sv | 147 ++++++++++++++
 tb/tb_alu_rs.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued micro-ops until both operands arrive, dispatches the lowest ready entry.
// Ready-at-issue ops dispatch one edge after issue; the issuer must hold off while full, and the ALU never stalls dispatch.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,
  input  logic               iss_valid,
  input  logic [2:0]         iss_op,
  input  logic [6:0]         iss_op_type,
  input  logic               iss_op_addition,
  input  logic [ROB_BIT-1:0] iss_rob_entry,
  input  logic [31:0]        iss_vi,
  input  logic [31:0]        iss_vj,
  input  logic               iss_qi_busy,
  input  logic               iss_qj_busy,
  input  logic [ROB_BIT-1:0] iss_qi,
  input  logic [ROB_BIT-1:0] iss_qj,
  output logic               full,
  input  logic               cdb_alu_ready,
  input  logic [ROB_BIT-1:0] cdb_alu_entry,
  input  logic [31:0]        cdb_alu_res,
  input  logic               cdb_lsb_ready,
  input  logic [ROB_BIT-1:0] cdb_lsb_entry,
  input  logic [31:0]        cdb_lsb_res,
  output logic               alu_valid,
  output logic [31:0]        alu_vi,
  output logic [31:0]        alu_vj,
  output logic [2:0]         alu_op,
  output logic [6:0]         alu_op_type,
  output logic               alu_op_addition,
  output logic [ROB_BIT-1:0] alu_rob_entry
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE) + 1;

  typedef struct packed {
    logic               busy;
    logic [2:0]         op;
    logic [6:0]         op_type;
    logic               op_addition;
    logic [ROB_BIT-1:0] rob;
    logic [31:0]        vi;
    logic [31:0]        vj;
    logic               qi_busy;
    logic               qj_busy;
    logic [ROB_BIT-1:0] qi;
    logic [ROB_BIT-1:0] qj;
  } rs_ent_t;

  rs_ent_t          ent [RS_SIZE];
  rs_ent_t          nxt [RS_SIZE];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             sel_vld;
  logic             free_vld;
  logic             iss_acc;

  // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] capture(input logic q_busy, input logic [ROB_BIT-1:0] q,
                                          input logic [31:0] v);
    if (q_busy && cdb_alu_ready && (q == cdb_alu_entry)) return {1'b0, cdb_alu_res};
    if (q_busy && cdb_lsb_ready && (q == cdb_lsb_entry)) return {1'b0, cdb_lsb_res};
    return {q_busy, v};
  endfunction

  assign full    = (count == CNT_W'(RS_SIZE));
  assign iss_acc = iss_valid && !full && free_vld;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ent[i].busy && !ent[i].qi_busy && !ent[i].qj_busy) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!ent[i].busy) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      nxt[i] = ent[i];
      if (ent[i].busy) begin
        {nxt[i].qi_busy, nxt[i].vi} = capture(ent[i].qi_busy, ent[i].qi, ent[i].vi);
        {nxt[i].qj_busy, nxt[i].vj} = capture(ent[i].qj_busy, ent[i].qj, ent[i].vj);
      end
    end
    if (sel_vld) nxt[sel_idx].busy = 1'b0;
    if (iss_acc) begin
      nxt[free_idx].busy        = 1'b1;
      nxt[free_idx].op          = iss_op;
      nxt[free_idx].op_type     = iss_op_type;
      nxt[free_idx].op_addition = iss_op_addition;
      nxt[free_idx].rob         = iss_rob_entry;
      nxt[free_idx].qi          = iss_qi;
      nxt[free_idx].qj          = iss_qj;
      {nxt[free_idx].qi_busy, nxt[free_idx].vi} = capture(iss_qi_busy, iss_qi, iss_vi);
      {nxt[free_idx].qj_busy, nxt[free_idx].vj} = capture(iss_qj_busy, iss_qj, iss_vj);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      count           <= '0;
      alu_valid       <= 1'b0;
      alu_vi          <= '0;
      alu_vj          <= '0;
      alu_op          <= '0;
      alu_op_type     <= '0;
      alu_op_addition <= 1'b0;
      alu_rob_entry   <= '0;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
        count     <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) ent[i] <= nxt[i];
        count     <= count + CNT_W'(iss_acc) - CNT_W'(sel_vld);
        alu_valid <= sel_vld;
        if (sel_vld) begin
          alu_vi          <= ent[sel_idx].vi;
          alu_vj          <= ent[sel_idx].vj;
          alu_op          <= ent[sel_idx].op;
          alu_op_type     <= ent[sel_idx].op_type;
          alu_op_addition <= ent[sel_idx].op_addition;
          alu_rob_entry   <= ent[sel_idx].rob;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: slot-level behavioural model checked every cycle, plus directed literal checks.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;
  logic        iss_valid = 1'b0;
  logic [2:0]  iss_op = '0;
  logic [6:0]  iss_op_type = '0;
  logic        iss_op_addition = 1'b0;
  logic [3:0]  iss_rob_entry = '0;
  logic [31:0] iss_vi = '0, iss_vj = '0;
  logic        iss_qi_busy = 1'b0, iss_qj_busy = 1'b0;
  logic [3:0]  iss_qi = '0, iss_qj = '0;
  logic        full;
  logic        cdb_alu_ready = 1'b0, cdb_lsb_ready = 1'b0;
  logic [3:0]  cdb_alu_entry = '0, cdb_lsb_entry = '0;
  logic [31:0] cdb_alu_res = '0, cdb_lsb_res = '0;
  logic        alu_valid;
  logic [31:0] alu_vi, alu_vj;
  logic [2:0]  alu_op;
  logic [6:0]  alu_op_type;
  logic        alu_op_addition;
  logic [3:0]  alu_rob_entry;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  alu_rs #(.RS_SIZE(8), .ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n), .rdy_in(rdy), .rob_clear_up(clr),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_op_type(iss_op_type),
    .iss_op_addition(iss_op_addition), .iss_rob_entry(iss_rob_entry),
    .iss_vi(iss_vi), .iss_vj(iss_vj), .iss_qi_busy(iss_qi_busy), .iss_qj_busy(iss_qj_busy),
    .iss_qi(iss_qi), .iss_qj(iss_qj), .full(full),
    .cdb_alu_ready(cdb_alu_ready), .cdb_alu_entry(cdb_alu_entry), .cdb_alu_res(cdb_alu_res),
    .cdb_lsb_ready(cdb_lsb_ready), .cdb_lsb_entry(cdb_lsb_entry), .cdb_lsb_res(cdb_lsb_res),
    .alu_valid(alu_valid), .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_op(alu_op),
    .alu_op_type(alu_op_type), .alu_op_addition(alu_op_addition), .alu_rob_entry(alu_rob_entry)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model: eight slots of pending micro-ops ----------------
  bit        m_busy [8];
  bit [2:0]  m_op [8];
  bit [6:0]  m_ty [8];
  bit        m_add [8];
  bit [3:0]  m_rob [8];
  bit [31:0] m_vi [8], m_vj [8];
  bit        m_qib [8], m_qjb [8];
  bit [3:0]  m_qi [8], m_qj [8];
  bit        e_valid = 1'b0;
  bit [31:0] e_vi = '0, e_vj = '0;
  bit [2:0]  e_op = '0;
  bit [6:0]  e_ty = '0;
  bit        e_add = 1'b0;
  bit [3:0]  e_rob = '0;
  int        d, f, occ;
  logic      hit;
  logic [31:0] bv;

  task automatic bus_val(input logic [3:0] tag, output logic h, output logic [31:0] v);
    h = 1'b1;
    if (cdb_alu_ready && cdb_alu_entry == tag) v = cdb_alu_res;
    else if (cdb_lsb_ready && cdb_lsb_entry == tag) v = cdb_lsb_res;
    else begin h = 1'b0; v = '0; end
  endtask

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      e_valid = 0; e_vi = 0; e_vj = 0; e_op = 0; e_ty = 0; e_add = 0; e_rob = 0;
    end else if (rdy) begin
      if (clr) begin
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
        e_valid = 1'b0;
      end else begin
        d = -1; f = -1; occ = 0;
        for (int i = 0; i < 8; i++) begin
          if (m_busy[i]) occ++;
          if (d < 0 && m_busy[i] && !m_qib[i] && !m_qjb[i]) d = i;
          if (f < 0 && !m_busy[i]) f = i;
        end
        for (int i = 0; i < 8; i++) begin
          if (m_busy[i] && m_qib[i]) begin
            bus_val(m_qi[i], hit, bv);
            if (hit) begin m_qib[i] = 0; m_vi[i] = bv; end
          end
          if (m_busy[i] && m_qjb[i]) begin
            bus_val(m_qj[i], hit, bv);
            if (hit) begin m_qjb[i] = 0; m_vj[i] = bv; end
          end
        end
        e_valid = (d >= 0);
        if (d >= 0) begin
          e_vi = m_vi[d]; e_vj = m_vj[d]; e_op = m_op[d]; e_ty = m_ty[d];
          e_add = m_add[d]; e_rob = m_rob[d]; m_busy[d] = 1'b0;
        end
        if (iss_valid && occ < 8) begin
          m_busy[f] = 1; m_op[f] = iss_op; m_ty[f] = iss_op_type; m_add[f] = iss_op_addition;
          m_rob[f] = iss_rob_entry; m_qi[f] = iss_qi; m_qj[f] = iss_qj;
          m_qib[f] = iss_qi_busy; m_vi[f] = iss_vi; m_qjb[f] = iss_qj_busy; m_vj[f] = iss_vj;
          if (iss_qi_busy) begin bus_val(iss_qi, hit, bv); if (hit) begin m_qib[f] = 0; m_vi[f] = bv; end end
          if (iss_qj_busy) begin bus_val(iss_qj, hit, bv); if (hit) begin m_qjb[f] = 0; m_vj[f] = bv; end end
        end
      end
    end
  end

  int occ_now;
  always @(negedge clk_in) begin
    if (cmp_on) begin
      occ_now = 0;
      for (int i = 0; i < 8; i++) if (m_busy[i]) occ_now++;
      chk("cmp_valid", 32'(alu_valid), 32'(e_valid));
      chk("cmp_full", 32'(full), 32'(occ_now == 8));
      chk("cmp_vi", alu_vi, e_vi);
      chk("cmp_vj", alu_vj, e_vj);
      chk("cmp_op", 32'(alu_op), 32'(e_op));
      chk("cmp_type", 32'(alu_op_type), 32'(e_ty));
      chk("cmp_add", 32'(alu_op_addition), 32'(e_add));
      chk("cmp_rob", 32'(alu_rob_entry), 32'(e_rob));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic quiet();
    iss_valid = 0; cdb_alu_ready = 0; cdb_lsb_ready = 0; clr = 0;
  endtask

  task automatic iss(input logic [3:0] rob, input logic [31:0] vi, input logic [31:0] vj,
                     input logic qib, input logic [3:0] qi, input logic qjb, input logic [3:0] qj);
    iss_valid = 1; iss_rob_entry = rob; iss_op = rob[2:0]; iss_op_addition = rob[2];
    case (rob[1:0])
      2'd1:    iss_op_type = 7'b0010011;
      2'd2:    iss_op_type = 7'b1100011;
      default: iss_op_type = 7'b0110011;
    endcase
    iss_vi = vi; iss_vj = vj; iss_qi_busy = qib; iss_qi = qi; iss_qj_busy = qjb; iss_qj = qj;
  endtask

  task automatic bc_alu(input logic [3:0] tag, input logic [31:0] res);
    cdb_alu_ready = 1; cdb_alu_entry = tag; cdb_alu_res = res;
  endtask

  task automatic bc_lsb(input logic [3:0] tag, input logic [31:0] res);
    cdb_lsb_ready = 1; cdb_lsb_entry = tag; cdb_lsb_res = res;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_valid", 32'(alu_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_vi", alu_vi, 32'd0);
    chk("rst_rob", 32'(alu_rob_entry), 32'd0);
    rst_n = 1; cmp_on = 1;

    // basic ADD, ready at issue
    iss(4'd3, 32'd5, 32'd7, 0, 0, 0, 0); iss_op = 3'b000; iss_op_type = 7'b0110011; iss_op_addition = 0;
    tick(); quiet();
    chk("basic_wait", 32'(alu_valid), 32'd0);
    tick();
    chk("basic_valid", 32'(alu_valid), 32'd1);
    chk("basic_vi", alu_vi, 32'd5);
    chk("basic_vj", alu_vj, 32'd7);
    chk("basic_rob", 32'(alu_rob_entry), 32'd3);
    chk("basic_type", 32'(alu_op_type), 32'b0110011);
    chk("basic_full", 32'(full), 32'd0);
    tick();
    chk("basic_strobe", 32'(alu_valid), 32'd0);

    // wakeup from LSB bus
    iss(4'd5, 32'd1, 32'd0, 0, 0, 1, 4'd2); tick(); quiet();
    bc_lsb(4'd2, 32'h10); tick(); quiet();
    chk("dep_wait", 32'(alu_valid), 32'd0);
    tick();
    chk("dep_valid", 32'(alu_valid), 32'd1);
    chk("dep_vj", alu_vj, 32'h10);
    chk("dep_rob", 32'(alu_rob_entry), 32'd5);

    // same-cycle bypass, then both buses on one tag
    iss(4'd6, 32'd0, 32'd3, 1, 4'd4, 0, 0); bc_alu(4'd4, 32'd9); tick(); quiet(); tick();
    chk("byp_valid", 32'(alu_valid), 32'd1);
    chk("byp_vi", alu_vi, 32'd9);
    chk("byp_rob", 32'(alu_rob_entry), 32'd6);
    iss(4'd7, 32'd0, 32'd3, 1, 4'd1, 0, 0); bc_alu(4'd1, 32'hAA); bc_lsb(4'd1, 32'hBB);
    tick(); quiet(); tick();
    chk("byp_prio_vi", alu_vi, 32'hAA);

    // fill, drop a ninth issue, then ordered wakeups
    for (int t = 0; t < 8; t++) begin
      iss(4'(t + 8), 32'd0, 32'(t), 1, 4'(t), 0, 0); tick();
    end
    quiet();
    chk("full_set", 32'(full), 32'd1);
    iss(4'd2, 32'h99, 32'd0, 0, 0, 0, 0); tick(); quiet(); tick();
    chk("full_drop", 32'(alu_valid), 32'd0);
    bc_alu(4'd7, 32'h70); tick(); quiet();
    chk("ord_full_hold", 32'(full), 32'd1);
    bc_alu(4'd6, 32'h60); tick(); quiet();
    chk("ord1_valid", 32'(alu_valid), 32'd1);
    chk("ord1_rob", 32'(alu_rob_entry), 32'd15);
    chk("ord1_vi", alu_vi, 32'h70);
    chk("ord1_full", 32'(full), 32'd0);
    bc_alu(4'd5, 32'h50); tick(); quiet();
    chk("ord2_rob", 32'(alu_rob_entry), 32'd14);
    chk("ord2_vi", alu_vi, 32'h60);
    tick();
    chk("ord3_rob", 32'(alu_rob_entry), 32'd13);
    chk("ord3_vi", alu_vi, 32'h50);
    tick();
    chk("ord_end", 32'(alu_valid), 32'd0);

    // slots 1, 4 and 6 become ready together
    iss(4'd5, 32'd0, 32'd0, 1, 4'd12, 0, 0); tick();
    iss(4'd6, 32'h66, 32'd0, 0, 0, 1, 4'd1); tick(); quiet();
    bc_alu(4'd1, 32'h11); bc_lsb(4'd4, 32'h44); tick(); quiet();
    tick();
    chk("multi1_rob", 32'(alu_rob_entry), 32'd9);
    chk("multi1_vi", alu_vi, 32'h11);
    tick();
    chk("multi2_rob", 32'(alu_rob_entry), 32'd12);
    chk("multi2_vi", alu_vi, 32'h44);
    tick();
    chk("multi3_rob", 32'(alu_rob_entry), 32'd6);
    chk("multi3_vj", alu_vj, 32'h11);
    chk("multi3_valid", 32'(alu_valid), 32'd1);
    tick();
    chk("multi_end", 32'(alu_valid), 32'd0);
    iss(4'd1, 32'd0, 32'd0, 1, 4'd13, 0, 0); tick(); quiet();

    // flush with five occupied entries, issue and broadcasts in flight
    clr = 1; iss(4'd2, 32'd1, 32'd2, 0, 0, 0, 0); bc_alu(4'd0, 32'h1); bc_lsb(4'd2, 32'h2);
    tick(); quiet();
    chk("fl_valid", 32'(alu_valid), 32'd0);
    chk("fl_full", 32'(full), 32'd0);
    bc_alu(4'd0, 32'h5); bc_lsb(4'd3, 32'h6); tick(); quiet();
    bc_alu(4'd12, 32'h7); bc_lsb(4'd13, 32'h8); tick(); quiet();
    tick();
    chk("fl_stale", 32'(alu_valid), 32'd0);
    for (int t = 0; t < 7; t++) begin
      iss(4'(t), 32'd0, 32'd0, 1, 4'd15, 0, 0); tick();
    end
    quiet();
    chk("fl_count7", 32'(full), 32'd0);
    iss(4'd7, 32'd0, 32'd0, 1, 4'd15, 0, 0); tick(); quiet();
    chk("fl_count8", 32'(full), 32'd1);
    clr = 1; tick(); quiet();
    chk("fl2_full", 32'(full), 32'd0);

    // freeze with broadcasts and issue pending
    iss(4'd4, 32'd0, 32'd0, 1, 4'd5, 0, 0); tick();
    iss(4'd1, 32'h21, 32'h22, 0, 0, 0, 0); tick(); quiet();
    tick();
    chk("frz_pre_valid", 32'(alu_valid), 32'd1);
    chk("frz_pre_rob", 32'(alu_rob_entry), 32'd1);
    rdy = 0; bc_alu(4'd5, 32'h55); iss(4'd3, 32'd1, 32'd1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_valid", 32'(alu_valid), 32'd1);
      chk("frz_rob", 32'(alu_rob_entry), 32'd1);
    end
    quiet(); rdy = 1; tick();
    chk("frz_nowake", 32'(alu_valid), 32'd0);
    bc_alu(4'd5, 32'h55); tick(); quiet(); tick();
    chk("frz_wake_rob", 32'(alu_rob_entry), 32'd4);
    chk("frz_wake_vi", alu_vi, 32'h55);
    tick();

    // asynchronous reset between edges
    for (int t = 0; t < 8; t++) begin
      iss(4'(t), 32'd0, 32'd0, 1, 4'd14, 0, 0); tick();
    end
    quiet();
    chk("ar_full_pre", 32'(full), 32'd1);
    #2 rst_n = 0;
    #1 chk("ar_full", 32'(full), 32'd0);
    #1 rst_n = 1;
    iss(4'd2, 32'd3, 32'd4, 0, 0, 0, 0); tick(); quiet(); tick();
    chk("ar_valid_pre", 32'(alu_valid), 32'd1);
    #2 rst_n = 0;
    #1 chk("ar_valid", 32'(alu_valid), 32'd0);
    chk("ar_vi", alu_vi, 32'd0);
    #1 rst_n = 1;
    tick();
    chk("ar_after", 32'(alu_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
